usb_dfu_dnload_buffer: RTL

//  Write-side feeder for the SPI flash bridge. Buffers one DFU_DNLOAD block from the USB OUT endpoint

---
 rtl/usb_dfu_dnload_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/usb_dfu_dnload_buffer.sv
// usb_dfu_dnload_buffer: buffers one DFU_DNLOAD block in a byte FIFO and feeds it to the SPI flash bridge.
// Optional feature: define DNLOAD_BLANK_SKIP_EN to skip writing blocks that are entirely 8'hFF.
module usb_dfu_dnload_buffer #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        block_start,
    input  logic [15:0] block_num,
    input  logic        block_end,
    input  logic        abort,
    input  logic        out_data_put,
    input  logic [7:0]  out_data,
    output logic        out_data_free,
    output logic [15:0] address,
    output logic        wr_request,
    output logic        wr_data_avail,
    output logic [7:0]  wr_data,
    input  logic        wr_data_get,
    input  logic        flash_busy,
    output logic        dnload_busy,
    output logic        dnload_done,
    output logic        dnload_error
);
    localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, REQUEST = 3'd2, DRAIN = 3'd3, FINISH = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic [15:0]   address_q;
    logic          wr_request_q, wr_request_d, error_q, error_d;
    logic          full, empty, push, pop, clear, skip;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign push  = state_q == FILL && out_data_put && !full;
    assign pop   = state_q == DRAIN && wr_data_get && !empty;

`ifdef DNLOAD_BLANK_SKIP_EN
    // blank_d already reflects a byte pushed in the same cycle as block_end
    logic blank_q, blank_d;
    assign blank_d = state_q == IDLE ? 1'b1 : blank_q && !(push && out_data != 8'hFF);
    assign skip    = blank_d;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) blank_q <= 1'b1;
        else          blank_q <= blank_d;
    end
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        wr_request_d = wr_request_q;
        clear        = 1'b0;
        error_d      = error_q || (state_q == FILL && out_data_put && full) || (wr_data_get && empty);
        if (abort) begin
            state_d      = IDLE;
            wr_request_d = 1'b0;
            clear        = 1'b1;
            error_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (block_start) begin
                    state_d = FILL;
                    clear   = 1'b1;
                    error_d = 1'b0;
                end
                FILL: if (block_end) begin
                    state_d = (skip || (empty && !push)) ? FINISH : REQUEST;
                    clear   = skip;
                end
                REQUEST: if (!flash_busy) begin
                    state_d      = DRAIN;
                    wr_request_d = 1'b1;
                end
                DRAIN: if (pop && cnt_q == (AW+1)'(1)) begin
                    state_d      = FINISH;
                    wr_request_d = 1'b0;
                end
                FINISH:  state_d = flash_busy ? FINISH : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            address_q    <= '0;
            wr_request_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_request_q <= wr_request_d;
            error_q      <= error_d;
            if (state_q == IDLE && block_start && !abort) address_q <= block_num;
            if (clear) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                wptr_q <= wptr_q + AW'(push);
                rptr_q <= rptr_q + AW'(pop);
                cnt_q  <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= out_data;
    end

    assign out_data_free = state_q == FILL && !full;
    assign address       = address_q;
    assign wr_request    = wr_request_q;
    assign wr_data_avail = state_q == DRAIN && !empty;
    assign wr_data       = wr_data_avail ? mem_q[rptr_q] : 8'h00;
    assign dnload_busy   = state_q != IDLE;
    assign dnload_done   = state_q == FINISH && !flash_busy && !abort;
    assign dnload_error  = error_q;
endmodule
